// File: rtl/text_cell_arbiter.sv
// Single-port character-cell RAM arbiter: scan-out reads always win, queued
// text writes and the full-grid clear sequencer share the leftover cycles.
module text_cell_arbiter #(
    parameter int unsigned CELLS      = 300,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_oob,
    input  logic                          clr_start,
    output logic                          clr_busy,
    output logic                          clr_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              rd_ok;
    logic              pop;
    logic              push;
    logic              oob_accept;
    logic              clr_adv;
    logic              flush;
    wr_entry_t         fifo_q [FIFO_DEPTH];
    wr_entry_t         head;

    assign head       = fifo_q[rd_ptr];
    assign push       = wr_valid && wr_ready && (wr_addr < ADDR_W'(CELLS));
    assign oob_accept = wr_valid && wr_ready && (wr_addr >= ADDR_W'(CELLS));
    assign flush      = (state == IDLE) && clr_start;

    // Out-of-range reads and idle cycles return zero; gating also keeps rd_data at 0 in reset.
    assign rd_data = rd_ok ? mem_rdata : '0;

    // Port grant and next state: read > clear > queued write.
    always_comb begin
        next_state = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        pop        = 1'b0;
        clr_adv    = 1'b0;
        wr_ready   = 1'b0;
        if (!rst) begin
            wr_ready = (state == IDLE) && (fifo_count < CNT_W'(FIFO_DEPTH)) && !clr_start;
            if (rd_req) begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end else if (state == CLEAR) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_ptr;
                clr_adv  = 1'b1;
            end else if ((fifo_count != '0) && !clr_start) begin
                // A clear request discards the queue, so its head is not written either.
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head.addr;
                mem_wdata = head.data;
                pop       = 1'b1;
            end
            case (state)
                IDLE:    if (clr_start) next_state = CLEAR;
                CLEAR:   if (clr_adv && (clr_ptr == ADDR_W'(CELLS - 1))) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clr_ptr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_valid   <= 1'b0;
            rd_ok      <= 1'b0;
            wr_oob     <= 1'b0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            state    <= next_state;
            rd_valid <= rd_req;
            rd_ok    <= rd_req && (rd_addr < ADDR_W'(CELLS));
            wr_oob   <= oob_accept;
            clr_busy <= (next_state == CLEAR);
            clr_done <= (state == CLEAR) && (next_state == IDLE);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                clr_ptr    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
                else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
                if (clr_adv) clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end
    end

    // Queue payload storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= '{addr: wr_addr, data: wr_data};
    end

endmodule

// File: doc/text_cell_arbiter.md
# text_cell_arbiter

Arbitrates a single-port synchronous character-cell memory (20×15 grid, one entry per 32×32-pixel tile of the 640×480 active area) between two requesters. The display scan-out path issues reads and always wins. Text writers push cell updates through a small FIFO that drains only in cycles the scan-out leaves idle. A clear sequencer can wipe the whole grid to code 0. The block sits between the VGA timing/pixel logic and the cell RAM.

## Interface
- `CELLS`, 300, number of cells; valid addresses are 0..CELLS-1
- `ADDR_W`, 9, cell address width
- `DATA_W`, 8, character code width
- `FIFO_DEPTH`, 4, pending-write slots; must be a power of 2

- `clk`  in  1  pixel clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rd_req`  in  1  scan-out read request for this cycle
- `rd_addr`  in  ADDR_W  scan-out cell address
- `rd_valid`  out  1  `rd_data` valid; asserted the cycle after `rd_req`
- `rd_data`  out  DATA_W  cell code read back
- `wr_valid`  in  1  writer has an update
- `wr_ready`  out  1  update accepted this cycle when `wr_valid` is high
- `wr_addr`  in  ADDR_W  target cell
- `wr_data`  in  DATA_W  character code
- `wr_oob`  out  1  one-cycle pulse: an accepted write had address ≥ CELLS and was dropped
- `clr_start`  in  1  pulse; start a full-grid clear
- `clr_busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse after the last cell is cleared
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  pending writes
- `mem_en`, `mem_we`  out  1  memory port enable and write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; registered, valid 1 cycle after a read

## Operation
- States: IDLE and CLEAR.
- Port grant is decided combinationally each cycle, in strict priority order:
  1. `rd_req`: `mem_en`=1, `mem_we`=0, `mem_addr`=`rd_addr`.
  2. State CLEAR: write 0 to `clr_ptr`, then increment `clr_ptr`.
  3. FIFO not empty: pop the head and write it.
  4. Otherwise: `mem_en`=0.
- `wr_ready` = (state==IDLE) && (count<FIFO_DEPTH) && !`clr_start`. It is evaluated on the pre-pop count, so a full FIFO does not accept a push even in a cycle where it pops.
- Push and pop in the same cycle leave `fifo_count` unchanged. Head-of-queue order is preserved.
- Out-of-range write (`wr_addr` ≥ CELLS):
  - it is accepted (handshake completes) and not enqueued;
  - `wr_oob` pulses on the next cycle.
- Out-of-range read:
  - the memory is still driven;
  - `rd_data` is forced to 0 in the response cycle.
- `clr_start` in IDLE:
  - the FIFO is flushed and pending writes are discarded;
  - `clr_ptr`←0 and the state moves to CLEAR;
  - `clr_busy` goes high on the next cycle.
- `clr_start` while already in CLEAR is ignored.
- CLEAR → IDLE on the cycle in which cell CELLS-1 is written. `clr_done` pulses and `clr_busy` falls on the following cycle.
- Reads are never stalled by a clear or by pending writes.

## Timing
- Read latency: `rd_valid`/`rd_data` arrive exactly 1 cycle after `rd_req`, registered.
- Write latency: the earliest memory write is the cycle after acceptance, provided `rd_req`=0 in that cycle.
- Clear duration: CELLS + (number of `rd_req` cycles during the clear).
- Reset, asynchronous, applies immediately:
  - `rd_valid`=0, `rd_data`=0, `wr_oob`=0, `clr_busy`=0, `clr_done`=0;
  - FIFO empty, `fifo_count`=0, state IDLE, `clr_ptr`=0;
  - while `rst` is high: `mem_en`=0, `mem_we`=0, `wr_ready`=0.
- Reset asserted mid-clear or mid-drain abandons the operation. Memory contents are not restored.
- Memory outputs are combinational from state and inputs. There is no pipeline bubble between a read and a following write.

## Test plan
- Read priority:
  - stimulus: `rd_req`=1 every cycle for 10 cycles; push writes (addr 5, 0x41) and (6, 0x42).
  - required: `mem_we` stays 0 for all 10 cycles; `fifo_count`=2; once `rd_req` drops, the two writes go out on consecutive cycles in order; a read of addr 5 then returns 0x41 with 1-cycle latency.
- FIFO full:
  - stimulus: hold `rd_req`=1 and push 5 writes back-to-back.
  - required: the first 4 are accepted; `wr_ready`=0 on the 5th; `fifo_count`=4.
- Out-of-range:
  - stimulus: write addr 300; then read addr 300.
  - required: the write handshakes with `wr_oob`=1 one cycle later and no `mem_we`; the read gives `rd_data`=0 with `rd_valid`=1.
- Clear with interleaved reads:
  - stimulus: preload cells 0 and 299 nonzero; push 2 writes; pulse `clr_start`; assert `rd_req` on every 4th cycle.
  - required: the pending writes are never issued; `clr_busy` lasts 300 + (number of read cycles) cycles; `clr_done` pulses once; all cells read 0 afterwards.
- Async reset mid-clear:
  - stimulus: assert `rst` at cell 150 for 2 cycles.
  - required: outputs go to reset values without waiting for a clock edge; after release the block is in IDLE with `wr_ready`=1 and cells 150..299 unchanged.
